trigger_sequencer: RTL and testbench

Programmable trigger scheduler that drives the `trigger` input of the clock-modulating datapath (half-rate gated clock and 25%/75% duty-cycle clock). On a start request it emits `repeat` frames. Each frame holds trigger high for `high_len` slow-clock periods, then low for `low_len` periods. All trigger edges align to slow-period boundaries of the selected datapath mode. It also drives the registered mode select consumed by the output mux, so the trigger source and mux select cannot disagree mid-sequence.

---
 rtl/trig_seq_pkg.sv | 25 ++
 rtl/trig_phase_gen.sv | 32 +++
 rtl/trigger_sequencer.sv | 155 +++++++++++++++
 tb/tb_trigger_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/trig_seq_pkg.sv
// Shared definitions for the trigger sequencer: FSM state codes, datapath mode
// encodings and the slow-clock period of each mode.
package trig_seq_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned PHASE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HIGH = 2'd1;
    localparam state_t ST_LOW  = 2'd2;

    localparam logic MODE_HALF = 1'b0;
    localparam logic MODE_DC   = 1'b1;

    localparam int unsigned P_HALF = 2;
    localparam int unsigned P_DC   = 4;

    // Phase value on which a slow period ends for the given mode.
    function automatic logic [PHASE_W-1:0] last_phase(input logic mode_i);
        return (mode_i == MODE_DC) ? PHASE_W'(P_DC - 1) : PHASE_W'(P_HALF - 1);
    endfunction

endpackage

// File: rtl/trig_phase_gen.sv
// Phase counter that marks slow-period boundaries of the selected datapath mode.
module trig_phase_gen
    import trig_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic mode,
    output logic tick_c
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    assign tick_c = (phase_q == last_phase(mode));

    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
        if (clr || tick_c) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Frame scheduler for the clock-modulating datapath: emits repeated high/low
// trigger frames aligned to slow-period boundaries and owns the mux select.
module trigger_sequencer
    import trig_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned REP_W = 8
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [REP_W-1:0] repeats,
    output logic             trigger,
    output logic             trig_sel,
    output logic             busy,
    output logic             done
);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   seg_q,      seg_d;
    logic [REP_W-1:0]   rep_q,      rep_d;
    logic [CNT_W-1:0]   high_cfg_q, high_cfg_d;
    logic [CNT_W-1:0]   low_cfg_q,  low_cfg_d;
    logic               sel_q,      sel_d;
    logic               trigger_q,  trigger_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               phase_clr_c;
    logic               tick_c;
    logic               frame_end_c;

    // Period follows the latched select so a mode change mid-sequence is invisible.
    trig_phase_gen u_phase (
        .clk    (fastclk),
        .rst_n  (reset),
        .clr    (phase_clr_c),
        .mode   (sel_q),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        rep_d       = rep_q;
        high_cfg_d  = high_cfg_q;
        low_cfg_d   = low_cfg_q;
        sel_d       = sel_q;
        done_d      = 1'b0;
        phase_clr_c = 1'b0;
        frame_end_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    sel_d       = mode;
                    high_cfg_d  = high_len;
                    low_cfg_d   = low_len;
                    rep_d       = repeats;
                    phase_clr_c = 1'b1;
                    if ((repeats == '0) || ((high_len == '0) && (low_len == '0))) begin
                        done_d = 1'b1;
                    end else if (high_len != '0) begin
                        state_d = ST_HIGH;
                        seg_d   = high_len;
                    end else begin
                        state_d = ST_LOW;
                        seg_d   = low_len;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    if (seg_q > CNT_W'(1)) begin
                        seg_d = seg_q - CNT_W'(1);
                    end else if (low_cfg_q != '0) begin
                        state_d = ST_LOW;
                        seg_d   = low_cfg_q;
                    end else begin
                        frame_end_c = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    if (seg_q > CNT_W'(1)) begin
                        seg_d = seg_q - CNT_W'(1);
                    end else begin
                        frame_end_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of frame: either start the next frame or finish the sequence.
        if (frame_end_c) begin
            if (rep_q > REP_W'(1)) begin
                rep_d = rep_q - REP_W'(1);
                if (high_cfg_q != '0) begin
                    state_d = ST_HIGH;
                    seg_d   = high_cfg_q;
                end else begin
                    state_d = ST_LOW;
                    seg_d   = low_cfg_q;
                end
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        trigger_d = (state_d == ST_HIGH);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            rep_q      <= '0;
            high_cfg_q <= '0;
            low_cfg_q  <= '0;
            sel_q      <= MODE_HALF;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            rep_q      <= rep_d;
            high_cfg_q <= high_cfg_d;
            low_cfg_q  <= low_cfg_d;
            sel_q      <= sel_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign trigger  = trigger_q;
    assign trig_sel = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: table of sequences checked against a
// per-cycle expected trace queue, plus abort, back-to-back and reset corner cases.
module tb_trigger_sequencer;

    logic       fastclk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       mode;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] repeats;
    logic       trigger;
    logic       trig_sel;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Expected {trigger, busy, done, trig_sel} per sampled cycle.
    logic [3:0] exp_q[$];

    typedef struct {
        logic       m;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] r;
        int         exp_busy;
        int         exp_high;
    } vec_t;

    vec_t vecs[6];

    trigger_sequencer #(.CNT_W(8), .REP_W(8)) dut (
        .fastclk  (fastclk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .high_len (high_len),
        .low_len  (low_len),
        .repeats  (repeats),
        .trigger  (trigger),
        .trig_sel (trig_sel),
        .busy     (busy),
        .done     (done)
    );

    always #5 fastclk = ~fastclk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h", name, {trigger, busy, done, trig_sel});
        end else begin
            e = exp_q.pop_front();
            check_val(name, {28'd0, trigger, busy, done, trig_sel}, {28'd0, e});
        end
    endtask

    // Expected trace from the frame arithmetic: frame = (H+L)*P cycles, first H*P high.
    task automatic push_trace(input logic m, input int h, input int l, input int r);
        int p;
        int f;
        int total;
        p     = m ? 4 : 2;
        f     = (h + l) * p;
        total = (r == 0 || f == 0) ? 0 : r * f;
        for (int k = 0; k < total; k++) begin
            exp_q.push_back({((k % f) < h * p) ? 1'b1 : 1'b0, 1'b1, 1'b0, m});
        end
        exp_q.push_back({1'b0, 1'b0, 1'b1, m});
        exp_q.push_back({1'b0, 1'b0, 1'b0, m});
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        int nbusy;
        int nhigh;
        int ndone;
        nbusy = 0;
        nhigh = 0;
        ndone = 0;
        @(negedge fastclk);
        mode     = v.m;
        high_len = v.h;
        low_len  = v.l;
        repeats  = v.r;
        start    = 1'b1;
        push_trace(v.m, int'(v.h), int'(v.l), int'(v.r));
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge fastclk);
            nbusy += int'(busy);
            nhigh += int'(trigger);
            ndone += int'(done);
            pop_check($sformatf("%s cyc%0d", name, k));
            if (k == 0) begin
                // Config must be latched; scrambling it afterwards has no effect.
                start    = 1'b0;
                mode     = ~v.m;
                high_len = 8'hFF;
                low_len  = 8'hFF;
                repeats  = 8'hFF;
            end
        end
        check_val({name, " busy_cycles"}, 32'(nbusy), 32'(v.exp_busy));
        check_val({name, " high_cycles"}, 32'(nhigh), 32'(v.exp_high));
        check_val({name, " done_pulses"}, 32'(ndone), 32'd1);
    endtask

    initial begin
        vecs[0] = '{m: 1'b0, h: 8'd2, l: 8'd3, r: 8'd2, exp_busy: 20, exp_high: 8};
        vecs[1] = '{m: 1'b1, h: 8'd1, l: 8'd0, r: 8'd3, exp_busy: 12, exp_high: 12};
        vecs[2] = '{m: 1'b0, h: 8'd2, l: 8'd3, r: 8'd0, exp_busy: 0,  exp_high: 0};
        vecs[3] = '{m: 1'b1, h: 8'd0, l: 8'd0, r: 8'd5, exp_busy: 0,  exp_high: 0};
        vecs[4] = '{m: 1'b1, h: 8'd0, l: 8'd2, r: 8'd2, exp_busy: 16, exp_high: 0};
        vecs[5] = '{m: 1'b0, h: 8'd3, l: 8'd1, r: 8'd1, exp_busy: 8,  exp_high: 6};

        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 1'b0;
        high_len = '0;
        low_len  = '0;
        repeats  = '0;
        repeat (3) @(negedge fastclk);
        exp_q.push_back(4'b0000);
        pop_check("reset_values");
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort during the first LOW segment of the 4/6 pattern.
        @(negedge fastclk);
        mode = 1'b0; high_len = 8'd2; low_len = 8'd3; repeats = 8'd2; start = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        for (int k = 0; k < 5; k++) exp_q.push_back(4'b0000);
        for (int k = 0; k < 10; k++) begin
            @(negedge fastclk);
            pop_check($sformatf("abort cyc%0d", k));
            start = 1'b0;
            abort = (k == 4);
        end

        // Start and abort together in IDLE: nothing launches, select is untouched.
        @(negedge fastclk);
        mode = 1'b1; high_len = 8'd1; low_len = 8'd1; repeats = 8'd1; start = 1'b1; abort = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge fastclk);
            pop_check($sformatf("start_abort cyc%0d", k));
            start = 1'b0;
            abort = 1'b0;
        end

        // Held start relaunches back-to-back; mid-sequence mode wiggle is ignored.
        @(negedge fastclk);
        mode = 1'b0; high_len = 8'd1; low_len = 8'd1; repeats = 8'd1; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(((k % 5) == 4) ? 4'b0010 : {((k % 5) < 2) ? 1'b1 : 1'b0, 3'b100});
        end
        exp_q.push_back(4'b0000);
        for (int k = 0; k < 11; k++) begin
            @(negedge fastclk);
            pop_check($sformatf("b2b cyc%0d", k));
            if (k == 1) mode = 1'b1;
            if (k == 3) mode = 1'b0;
            if (k == 9) start = 1'b0;
        end

        // Asynchronous reset in the middle of a HIGH segment.
        @(negedge fastclk);
        mode = 1'b1; high_len = 8'd1; low_len = 8'd0; repeats = 8'd3; start = 1'b1;
        @(negedge fastclk);
        start = 1'b0;
        exp_q.push_back(4'b1101);
        pop_check("pre_reset_high");
        @(negedge fastclk);
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(4'b0000);
        pop_check("async_reset");
        @(negedge fastclk);
        reset = 1'b1;
        run_vec(vecs[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
